uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 40, clk cycles per bit (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, rx synchroniser depth (>= 2).
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 SHALL have port err_clr  input  1  one-cycle pulse that clears the sticky overrun.
REQ-011 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-012 SHALL have port rx_valid  output  1  rx_data and status are valid.
REQ-013 SHALL have port frame_err  output  1  a stop bit of the held frame sampled low.
REQ-014 SHALL have port parity_err  output  1  parity mismatch in the held frame (0 when PARITY=0).
REQ-015 SHALL have port overrun  output  1  sticky: a completed frame was dropped.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 SHALL pass rx through SYNC_STAGES flops to give rx_s; all logic uses rx_s only.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-019 IDLE: rx_s low -> START, bit counter cleared; this is cycle t0.
REQ-020 SHALL sample bit k (k=0 start bit) at t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
REQ-021 START: start-bit sample high -> IDLE (glitch rejected, nothing delivered); low -> DATA.
REQ-022 DATA: shift DATA_BITS samples LSB first; then -> PAR if PARITY != 0, else -> STOP.
REQ-023 PAR: one sample; parity_err computed over data bits plus parity bit per PARITY mode.
REQ-024 STOP: STOP_BITS samples; any low sample sets frame_err for this frame.
REQ-025 SHALL deliver the frame in the cycle after the last stop-bit sample: rx_data, frame_err, parity_err loaded; rx_valid=1.
REQ-026 After delivery: frame_err=0 -> IDLE; frame_err=1 -> WAIT_HI until rx_s high (break tolerance), then IDLE.
REQ-027 rx_valid SHALL stay high, with rx_data and flags stable, until a cycle with rx_valid && rx_ready.
REQ-028 Accept without a new delivery in the same cycle SHALL clear rx_valid next cycle.
REQ-029 Accept and new delivery in the same cycle SHALL load the new frame, keep rx_valid=1, no overrun.
REQ-030 Delivery while rx_valid=1 and no accept SHALL discard the new frame, keep the old one, set overrun.
REQ-031 overrun SHALL clear only on err_clr; set and err_clr in the same cycle -> overrun stays 1.
REQ-032 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-033 rst high SHALL force IDLE immediately, from any state including mid-frame.
REQ-034 Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, counters=0.
REQ-035 Synchroniser flops SHALL reset to 1, so no false start after reset release.

Verification
REQ-036 Defaults; frame 0x55, 1 stop bit, rx_ready=1 -> one rx_valid pulse, rx_data=0x55, all flags 0.
REQ-037 Defaults; rx low for 15 clks then high -> no rx_valid; busy returns to 0 within CLKS_PER_BIT clks.
REQ-038 Defaults; frame 0xA3 with stop bit low, rx held low 2 more bit times -> rx_data=0xA3, frame_err=1, no second frame until rx high.
REQ-039 PARITY=2; frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-040 Defaults, rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x11, overrun=1; err_clr pulse -> overrun=0.
REQ-041 Defaults; rst pulsed during bit 3 of 0xFF -> all outputs 0 next edge; following 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: held word, status flags and handshake.
// The receiver drives it through the master modport.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_ready;
    logic                 err_clr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rx_ready, err_clr,
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy
    );

    modport slave (
        output rx_ready, err_clr,
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver. The rx line is synchronised and sampled mid-bit.
// The frame is held with a valid/ready handshake and carries frame/parity flags and a sticky overrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 40,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_param_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = 4;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
            $error("uart_rx_param: CLKS_PER_BIT must be even and >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_param: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HI
    } state_e;

    // Odd mode expects an odd count of ones over data plus parity bit, even mode an even count.
    function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic ones_odd;
        ones_odd = ^{data, pbit};
        case (PARITY)
            1:       parity_err_f = ~ones_odd;
            2:       parity_err_f = ones_odd;
            default: parity_err_f = 1'b0;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   ferr_acc_q, ferr_acc_d;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;

    logic                   deliver;
    logic                   deliver_ferr;
    logic                   accept;
    logic                   overrun_set;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        ferr_acc_d   = ferr_acc_q;
        deliver      = 1'b0;
        deliver_ferr = ferr_acc_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end

            // The first sample lands half a bit after the falling edge; later ones a full bit apart.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        ferr_acc_d = 1'b0;
                        par_d      = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PAR: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d        = '0;
                    deliver_ferr = ferr_acc_q | ~rx_s;
                    ferr_acc_d   = deliver_ferr;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        deliver = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover before re-arming.
                        state_d = deliver_ferr ? WAIT_HI : IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HI: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        accept       = rx_valid_q & bus.rx_ready;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        rx_valid_d   = rx_valid_q & ~accept;
        overrun_set  = 1'b0;

        // A finished frame only replaces the held one if the slot is free or being emptied now.
        if (deliver) begin
            if (!rx_valid_q || accept) begin
                rx_data_d    = shreg_q;
                frame_err_d  = deliver_ferr;
                parity_err_d = parity_err_f(shreg_q, par_q);
                rx_valid_d   = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        overrun_d = overrun_set | (overrun_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            ferr_acc_q   <= ferr_acc_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one default 8N1 receiver and one even-parity receiver.
// Expected words, flags and delivery latencies are hand-derived.
module tb_uart_rx_param;
    localparam int CPB   = 40;
    // Falling start edge to first rx_valid sample: 2 sync + CPB/2 + last-bit * CPB + 1.
    localparam int LAT   = 383;
    localparam int LAT_P = 423;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc0 = 0, start_cyc1 = 0;
    int rise_cnt0 = 0, rise_cyc0 = 0, rise_cnt1 = 0, rise_cyc1 = 0;
    logic [7:0] cap_data0 = '0, cap_data1 = '0;
    logic cap_ferr0 = 1'b0, cap_perr0 = 1'b0, cap_ferr1 = 1'b0, cap_perr1 = 1'b0;
    logic pv0 = 1'b0, pv1 = 1'b0;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

    uart_rx_param dut0 (.clk(clk), .rst(rst), .rx(rx0), .bus(bus0));
    uart_rx_param #(.PARITY(2)) dut1 (.clk(clk), .rst(rst), .rx(rx1), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising edge of rx_valid together with the word and flags it presents.
    always @(negedge clk) begin
        pv0 <= bus0.rx_valid;
        pv1 <= bus1.rx_valid;
        if (bus0.rx_valid && !pv0) begin
            rise_cnt0 <= rise_cnt0 + 1;
            rise_cyc0 <= cyc;
            cap_data0 <= bus0.rx_data;
            cap_ferr0 <= bus0.frame_err;
            cap_perr0 <= bus0.parity_err;
        end
        if (bus1.rx_valid && !pv1) begin
            rise_cnt1 <= rise_cnt1 + 1;
            rise_cyc1 <= cyc;
            cap_data1 <= bus1.rx_data;
            cap_ferr1 <= bus1.frame_err;
            cap_perr1 <= bus1.parity_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx1 = v;
        else rx0 = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic stop_lvl);
        if (sel) start_cyc1 = cyc;
        else start_cyc0 = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, pbit);
        drive_bit(sel, stop_lvl);
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (bus0.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", bus0.rx_data); end
        checks++; if (bus0.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus0.rx_valid); end
        checks++; if (bus0.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus0.frame_err); end
        checks++; if (bus0.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", bus0.parity_err); end
        checks++; if (bus0.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus0.overrun); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        checks++; if (bus1.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid1: got %b expected 0", bus1.rx_valid); end
        rst = 1'b0;
        idle(20);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL release_no_start: busy got %b expected 0", bus0.busy); end
    endtask

    task automatic test_basic();
        int n0;
        n0 = rise_cnt0;
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        idle(CPB);
        checks++; if (rise_cnt0 !== n0 + 1) begin errors++; $display("FAIL basic_count: got %0d expected %0d", rise_cnt0, n0 + 1); end
        checks++; if (cap_data0 !== 8'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", cap_data0); end
        checks++; if (cap_ferr0 !== 1'b0 || cap_perr0 !== 1'b0) begin errors++; $display("FAIL basic_flags: got ferr=%b perr=%b expected 0 0", cap_ferr0, cap_perr0); end
        checks++; if (rise_cyc0 - start_cyc0 !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc0 - start_cyc0, LAT); end
        checks++; if (bus0.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_cleared: got %b expected 0", bus0.rx_valid); end
        checks++; if (bus0.overrun !== 1'b0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got overrun=%b busy=%b expected 0 0", bus0.overrun, bus0.busy); end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = rise_cnt0;
        rx0 = 1'b0;
        idle(5);
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", bus0.busy); end
        idle(10);
        rx0 = 1'b1;
        idle(CPB);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", bus0.busy); end
        idle(10 * CPB);
        checks++; if (rise_cnt0 !== n0) begin errors++; $display("FAIL glitch_no_frame: got %0d frames expected %0d", rise_cnt0, n0); end
    endtask

    task automatic test_frame_err();
        int n0;
        n0 = rise_cnt0;
        send_frame(0, 8'hA3, 0, 1'b0, 1'b0);
        idle(2 * CPB);
        checks++; if (rise_cnt0 !== n0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", rise_cnt0, n0 + 1); end
        checks++; if (cap_data0 !== 8'hA3) begin errors++; $display("FAIL ferr_data: got %h expected a3", cap_data0); end
        checks++; if (cap_ferr0 !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", cap_ferr0); end
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_hi: busy got %b expected 1", bus0.busy); end
        rx0 = 1'b1;
        idle(10 * CPB);
        checks++; if (rise_cnt0 !== n0 + 1) begin errors++; $display("FAIL ferr_no_second: got %0d expected %0d", rise_cnt0, n0 + 1); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL ferr_recover: busy got %b expected 0", bus0.busy); end
    endtask

    task automatic test_parity();
        int n1;
        n1 = rise_cnt1;
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        idle(CPB);
        checks++; if (rise_cnt1 !== n1 + 1) begin errors++; $display("FAIL par_count: got %0d expected %0d", rise_cnt1, n1 + 1); end
        checks++; if (cap_data1 !== 8'h07) begin errors++; $display("FAIL par_data: got %h expected 07", cap_data1); end
        checks++; if (cap_perr1 !== 1'b1) begin errors++; $display("FAIL par_bad: parity_err got %b expected 1", cap_perr1); end
        checks++; if (rise_cyc1 - start_cyc1 !== LAT_P) begin errors++; $display("FAIL par_latency: got %0d expected %0d", rise_cyc1 - start_cyc1, LAT_P); end
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        idle(CPB);
        checks++; if (rise_cnt1 !== n1 + 2) begin errors++; $display("FAIL par_count2: got %0d expected %0d", rise_cnt1, n1 + 2); end
        checks++; if (cap_perr1 !== 1'b0 || cap_ferr1 !== 1'b0) begin errors++; $display("FAIL par_good: got perr=%b ferr=%b expected 0 0", cap_perr1, cap_ferr1); end
    endtask

    task automatic test_overrun();
        bus0.rx_ready = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1);
        checks++; if (bus0.rx_valid !== 1'b1 || bus0.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got valid=%b overrun=%b expected 1 0", bus0.rx_valid, bus0.overrun); end
        send_frame(0, 8'h22, 0, 1'b0, 1'b1);
        checks++; if (bus0.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_keep_old: got %h expected 11", bus0.rx_data); end
        checks++; if (bus0.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", bus0.overrun); end
        bus0.err_clr = 1'b1;
        @(negedge clk);
        bus0.err_clr = 1'b0;
        checks++; if (bus0.overrun !== 1'b0 || bus0.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_clear: got overrun=%b valid=%b expected 0 1", bus0.overrun, bus0.rx_valid); end
        // err_clr lands in the same cycle as the dropped delivery; the set must win.
        fork
            send_frame(0, 8'h33, 0, 1'b0, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                bus0.err_clr = 1'b1;
                @(negedge clk);
                bus0.err_clr = 1'b0;
            end
        join
        checks++; if (bus0.overrun !== 1'b1 || bus0.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_set_vs_clr: got overrun=%b data=%h expected 1 11", bus0.overrun, bus0.rx_data); end
        bus0.err_clr = 1'b1;
        @(negedge clk);
        bus0.err_clr = 1'b0;
        // Accept coincides with delivery: the new word replaces the old without overrun.
        fork
            send_frame(0, 8'h44, 0, 1'b0, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                bus0.rx_ready = 1'b1;
                @(negedge clk);
                bus0.rx_ready = 1'b0;
            end
        join
        checks++; if (bus0.rx_data !== 8'h44 || bus0.rx_valid !== 1'b1) begin errors++; $display("FAIL accept_and_load: got data=%h valid=%b expected 44 1", bus0.rx_data, bus0.rx_valid); end
        checks++; if (bus0.overrun !== 1'b0) begin errors++; $display("FAIL accept_no_overrun: got %b expected 0", bus0.overrun); end
        bus0.rx_ready = 1'b1;
        idle(2);
        checks++; if (bus0.rx_valid !== 1'b0) begin errors++; $display("FAIL drain: valid got %b expected 0", bus0.rx_valid); end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = rise_cnt0;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rx0 = 1'b1;
        idle(CPB / 2);
        checks++; if (bus0.busy !== 1'b1 || bus0.rx_data !== 8'h44) begin errors++; $display("FAIL mid_pre: got busy=%b data=%h expected 1 44", bus0.busy, bus0.rx_data); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus0.rx_data !== 8'h00 || bus0.rx_valid !== 1'b0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got data=%h valid=%b busy=%b expected 00 0 0", bus0.rx_data, bus0.rx_valid, bus0.busy); end
        checks++; if (bus0.frame_err !== 1'b0 || bus0.parity_err !== 1'b0 || bus0.overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b%b%b expected 000", bus0.frame_err, bus0.parity_err, bus0.overrun); end
        @(negedge clk);
        rst = 1'b0;
        idle(2 * CPB);
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL mid_release: busy got %b expected 0", bus0.busy); end
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        idle(CPB);
        checks++; if (rise_cnt0 !== n0 + 1) begin errors++; $display("FAIL mid_count: got %0d expected %0d", rise_cnt0, n0 + 1); end
        checks++; if (cap_data0 !== 8'h3C || cap_ferr0 !== 1'b0) begin errors++; $display("FAIL mid_data: got %h ferr=%b expected 3c 0", cap_data0, cap_ferr0); end
        checks++; if (rise_cyc0 - start_cyc0 !== LAT) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", rise_cyc0 - start_cyc0, LAT); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.rx_ready = 1'b1;
        bus0.err_clr  = 1'b0;
        bus1.rx_ready = 1'b1;
        bus1.err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
